// File: rtl/pll_power_sequencer.sv
// PLL power sequencer: drains the image buffer, moves the buffer clock to SPI,
// powers the PLL down on request, and on wake qualifies lock before handing
// the buffer clock back to the PLL. Single always-on clock domain.
module pll_power_sequencer #(
    parameter int LOCK_STABLE_CYCLES   = 1024,
    parameter int SWITCH_SETTLE_CYCLES = 8,
    parameter int LOCK_TIMEOUT_CYCLES  = 65535
) (
    input  logic       clock_in,
    input  logic       reset_in,
    input  logic       power_down_request_in,
    input  logic       buffer_busy_in,
    input  logic       pll_locked_in,
    output logic       pllpowerdown_n_out,
    output logic       image_buffer_clock_select_out,
    output logic       pll_ready_out,
    output logic       lock_timeout_out,
    output logic [2:0] state_out
);

    typedef enum logic [2:0] {
        ST_RUN           = 3'd0,
        ST_DRAIN         = 3'd1,
        ST_SWITCH_TO_SPI = 3'd2,
        ST_POWERED_DOWN  = 3'd3,
        ST_WAIT_LOCK     = 3'd4,
        ST_SWITCH_TO_PLL = 3'd5
    } state_t;

    localparam int STABLE_W  = $clog2(LOCK_STABLE_CYCLES + 1);
    localparam int SETTLE_W  = $clog2(SWITCH_SETTLE_CYCLES + 1);
    localparam int TIMEOUT_W = $clog2(LOCK_TIMEOUT_CYCLES + 1);

    localparam logic [STABLE_W-1:0]  STABLE_ONE     = STABLE_W'(1);
    localparam logic [STABLE_W-1:0]  STABLE_TARGET  = STABLE_W'(LOCK_STABLE_CYCLES);
    localparam logic [SETTLE_W-1:0]  SETTLE_ONE     = SETTLE_W'(1);
    localparam logic [SETTLE_W-1:0]  SETTLE_TARGET  = SETTLE_W'(SWITCH_SETTLE_CYCLES);
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_ONE    = TIMEOUT_W'(1);
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_TARGET = TIMEOUT_W'(LOCK_TIMEOUT_CYCLES);

    state_t               state_q, state_d;
    logic                 req_meta_q, req_meta_d, req_s_q, req_s_d;
    logic                 lock_meta_q, lock_meta_d, lock_s_q, lock_s_d;
    logic [STABLE_W-1:0]  stable_cnt_q, stable_cnt_d, stable_inc;
    logic [SETTLE_W-1:0]  settle_cnt_q, settle_cnt_d, settle_inc;
    logic [TIMEOUT_W-1:0] timeout_cnt_q, timeout_cnt_d, timeout_inc;
    logic                 lock_timeout_q, lock_timeout_d;
    logic                 pllpowerdown_n_q, pllpowerdown_n_d;
    logic                 select_q, select_d;
    logic                 ready_q, ready_d;

    // Next-state, counter and output decode; outputs follow the next state so
    // the registered outputs always agree with the registered state code.
    always_comb begin
        req_meta_d     = power_down_request_in;
        req_s_d        = req_meta_q;
        lock_meta_d    = pll_locked_in;
        lock_s_d       = lock_meta_q;
        state_d        = state_q;
        stable_inc     = stable_cnt_q + STABLE_ONE;
        settle_inc     = settle_cnt_q + SETTLE_ONE;
        timeout_inc    = timeout_cnt_q + TIMEOUT_ONE;
        stable_cnt_d   = stable_cnt_q;
        settle_cnt_d   = settle_cnt_q;
        timeout_cnt_d  = timeout_cnt_q;
        lock_timeout_d = lock_timeout_q;

        case (state_q)
            ST_RUN: begin
                // Lock loss outranks a power-down request.
                if (!lock_s_q)    state_d = ST_WAIT_LOCK;
                else if (req_s_q) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!req_s_q)             state_d = ST_RUN;
                else if (!buffer_busy_in) state_d = ST_SWITCH_TO_SPI;
            end
            ST_SWITCH_TO_SPI: begin
                if (settle_inc == SETTLE_TARGET) state_d = ST_POWERED_DOWN;
                else                             settle_cnt_d = settle_inc;
            end
            ST_POWERED_DOWN: begin
                if (!req_s_q) state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                // Timeout only flags; the sequencer keeps waiting for lock.
                if (timeout_inc == TIMEOUT_TARGET) begin
                    lock_timeout_d = 1'b1;
                    timeout_cnt_d  = '0;
                end else begin
                    timeout_cnt_d  = timeout_inc;
                end
                if (!lock_s_q)                     stable_cnt_d = '0;
                else                               stable_cnt_d = stable_inc;
                if (req_s_q)                       state_d = ST_SWITCH_TO_SPI;
                else if (lock_s_q && stable_inc == STABLE_TARGET)
                                                   state_d = ST_SWITCH_TO_PLL;
            end
            ST_SWITCH_TO_PLL: begin
                if (!lock_s_q)                        state_d = ST_WAIT_LOCK;
                else if (settle_inc == SETTLE_TARGET) state_d = ST_RUN;
                else                                  settle_cnt_d = settle_inc;
            end
            default: state_d = ST_WAIT_LOCK;
        endcase

        // Every state entry starts the counters from zero.
        if (state_d != state_q) begin
            stable_cnt_d  = '0;
            settle_cnt_d  = '0;
            timeout_cnt_d = '0;
        end

        // Select only moves while the PLL is powered, so it never toggles
        // together with powerdown_n.
        pllpowerdown_n_d = (state_d != ST_POWERED_DOWN);
        select_d = (state_d == ST_RUN) || (state_d == ST_DRAIN) ||
                   (state_d == ST_SWITCH_TO_PLL);
        ready_d  = (state_d == ST_RUN);
    end

    // State, synchronizers, counters and outputs with asynchronous reset.
    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            state_q          <= ST_WAIT_LOCK;
            req_meta_q       <= 1'b0;
            req_s_q          <= 1'b0;
            lock_meta_q      <= 1'b0;
            lock_s_q         <= 1'b0;
            stable_cnt_q     <= '0;
            settle_cnt_q     <= '0;
            timeout_cnt_q    <= '0;
            lock_timeout_q   <= 1'b0;
            pllpowerdown_n_q <= 1'b1;
            select_q         <= 1'b0;
            ready_q          <= 1'b0;
        end else begin
            state_q          <= state_d;
            req_meta_q       <= req_meta_d;
            req_s_q          <= req_s_d;
            lock_meta_q      <= lock_meta_d;
            lock_s_q         <= lock_s_d;
            stable_cnt_q     <= stable_cnt_d;
            settle_cnt_q     <= settle_cnt_d;
            timeout_cnt_q    <= timeout_cnt_d;
            lock_timeout_q   <= lock_timeout_d;
            pllpowerdown_n_q <= pllpowerdown_n_d;
            select_q         <= select_d;
            ready_q          <= ready_d;
        end
    end

    assign state_out                     = state_q;
    assign pllpowerdown_n_out            = pllpowerdown_n_q;
    assign image_buffer_clock_select_out = select_q;
    assign pll_ready_out                 = ready_q;
    assign lock_timeout_out              = lock_timeout_q;

endmodule

// File: tb/tb_pll_power_sequencer.sv
// Bench for pll_power_sequencer (LOCK_STABLE=4, SETTLE=2, TIMEOUT=16).
// Each output change is expected at a hand-computed cycle; the stimulus
// process queues {cycle, state, pd_n, sel, ready, timeout} and the monitor
// pops one entry whenever the DUT outputs change. Spot checks of steady
// outputs (reset values, sticky flag) go through a second queue.
module tb_pll_power_sequencer;

  localparam int W = 23;
  localparam logic [2:0] S_RUN   = 3'd0;
  localparam logic [2:0] S_DRAIN = 3'd1;
  localparam logic [2:0] S_SPI   = 3'd2;
  localparam logic [2:0] S_PD    = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_PLL   = 3'd5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req = 1'b0;
  logic       busy = 1'b0;
  logic       lock = 1'b1;
  logic       pd_n, sel, rdy, to;
  logic [2:0] st;

  int cyc = 0;
  int n_assert = 0;
  int n_fail = 0;
  logic done = 1'b0;

  logic [W-1:0] exp_q[$];
  logic [6:0]   spot_q[$];

  pll_power_sequencer #(
    .LOCK_STABLE_CYCLES(4),
    .SWITCH_SETTLE_CYCLES(2),
    .LOCK_TIMEOUT_CYCLES(16)
  ) dut (
    .clock_in(clk),
    .reset_in(rst),
    .power_down_request_in(req),
    .buffer_busy_in(busy),
    .pll_locked_in(lock),
    .pllpowerdown_n_out(pd_n),
    .image_buffer_clock_select_out(sel),
    .pll_ready_out(rdy),
    .lock_timeout_out(to),
    .state_out(st)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int c, input logic [2:0] s, input logic p,
                      input logic se, input logic r, input logic t);
    exp_q.push_back({16'(c), s, p, se, r, t});
  endtask

  task automatic spot(input logic [2:0] s, input logic p, input logic se,
                      input logic r, input logic t);
    spot_q.push_back({s, p, se, r, t});
  endtask

  // stimulus
  initial begin
    int c;
    repeat (3) @(negedge clk);
    spot(S_WAIT, 1'b1, 1'b0, 1'b0, 1'b0);

    // power-up with lock already high
    @(negedge clk);
    c = cyc; rst = 1'b0;
    push(c + 6, S_PLL, 1'b1, 1'b1, 1'b0, 1'b0);
    push(c + 8, S_RUN, 1'b1, 1'b1, 1'b1, 1'b0);
    repeat (10) @(negedge clk);

    // power-down, held in DRAIN while busy
    c = cyc; req = 1'b1; busy = 1'b1;
    push(c + 3, S_DRAIN, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    c = cyc; busy = 1'b0;
    push(c + 1, S_SPI, 1'b1, 1'b0, 1'b0, 1'b0);
    push(c + 3, S_PD, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (6) @(negedge clk);

    // wake, with a one-cycle lock glitch at stable count 3
    c = cyc; req = 1'b0;
    push(c + 3, S_WAIT, 1'b1, 1'b0, 1'b0, 1'b0);
    push(c + 11, S_PLL, 1'b1, 1'b1, 1'b0, 1'b0);
    push(c + 13, S_RUN, 1'b1, 1'b1, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    lock = 1'b0;
    @(negedge clk);
    lock = 1'b1;
    repeat (10) @(negedge clk);

    // abort: request dropped while draining
    c = cyc; req = 1'b1; busy = 1'b1;
    push(c + 3, S_DRAIN, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    c = cyc; req = 1'b0;
    push(c + 3, S_RUN, 1'b1, 1'b1, 1'b1, 1'b0);
    repeat (6) @(negedge clk);
    busy = 1'b0;

    // lock loss together with a request: WAIT_LOCK first, then SPI
    c = cyc; lock = 1'b0; req = 1'b1;
    push(c + 3, S_WAIT, 1'b1, 1'b0, 1'b0, 1'b0);
    push(c + 4, S_SPI, 1'b1, 1'b0, 1'b0, 1'b0);
    push(c + 6, S_PD, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (8) @(negedge clk);

    // lock timeout: 40+ cycles unlocked in WAIT_LOCK, then recover
    c = cyc; req = 1'b0;
    push(c + 3, S_WAIT, 1'b1, 1'b0, 1'b0, 1'b0);
    push(c + 19, S_WAIT, 1'b1, 1'b0, 1'b0, 1'b1);
    repeat (43) @(negedge clk);
    c = cyc; lock = 1'b1;
    push(c + 6, S_PLL, 1'b1, 1'b1, 1'b0, 1'b1);
    push(c + 8, S_RUN, 1'b1, 1'b1, 1'b1, 1'b1);
    repeat (10) @(negedge clk);
    spot(S_RUN, 1'b1, 1'b1, 1'b1, 1'b1);
    repeat (2) @(negedge clk);

    // asynchronous reset mid-RUN clears the sticky flag
    c = cyc;
    push(c + 1, S_WAIT, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    spot(S_WAIT, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    c = cyc; rst = 1'b0;
    push(c + 6, S_PLL, 1'b1, 1'b1, 1'b0, 1'b0);
    push(c + 8, S_RUN, 1'b1, 1'b1, 1'b1, 1'b0);
    repeat (12) @(negedge clk);
    done = 1'b1;
  end

  // monitor / scoreboard / final report
  initial begin
    logic [6:0]   prev_out;
    logic [6:0]   cur_out;
    logic [6:0]   spot_exp;
    logic [W-1:0] got;
    logic [W-1:0] exp_v;
    @(negedge clk);
    prev_out = {st, pd_n, sel, rdy, to};
    forever begin
      @(negedge clk);
      cur_out = {st, pd_n, sel, rdy, to};
      if (cur_out != prev_out) begin
        got = {16'(cyc), cur_out};
        n_assert++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_change: got cyc=%0d out=%b, expected no change", cyc, cur_out);
        end else begin
          exp_v = exp_q.pop_front();
          if (got !== exp_v) begin
            n_fail++;
            $display("FAIL out_change: got cyc=%0d out=%b, expected cyc=%0d out=%b",
                     got[W-1:7], got[6:0], exp_v[W-1:7], exp_v[6:0]);
          end
        end
        prev_out = cur_out;
      end
      if (spot_q.size() != 0) begin
        spot_exp = spot_q.pop_front();
        n_assert++;
        if (cur_out !== spot_exp) begin
          n_fail++;
          $display("FAIL steady_outputs: got out=%b at cyc=%0d, expected out=%b",
                   cur_out, cyc, spot_exp);
        end
      end
      if (done) begin
        n_assert++;
        if (exp_q.size() != 0) begin
          n_fail++;
          $display("FAIL missing_changes: got %0d pending, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
      end
    end
  end

endmodule
